pkt_router_4port: RTL and testbench



---
 rtl/pkt_pkg.sv | 24 ++
 rtl/pkt_fifo.sv | 52 +++++
 rtl/pkt_router_4port.sv | 133 +++++++++++++
 tb/tb_pkt_router_4port.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_pkg.sv
// Shared types for the 4-port packet router: flit layout, router FSM states
// and the default "discard" packet type.
package pkt_pkg;

  typedef struct packed {
    logic [1:0] dst_addr;
    logic [1:0] p_type;
    logic [7:0] payload;
    logic       eop;
  } flit_t;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP
  } router_state_t;

  localparam logic [1:0] PTYPE_DROP_DEFAULT = 2'b11;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Show-ahead flit FIFO: the head entry is on dout whenever empty is low.
// Pushes while full and pops while empty are ignored.
module pkt_fifo
  import pkt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  flit_t din,
  output flit_t dout,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  flit_t       mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    dout     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pkt_router_4port.sv
// Buffers incoming flits and steers each whole packet to one of four ports,
// dropping reserved-type packets. PKT_ROUTER_STATS_EN adds per-port packet counters.
module pkt_router_4port
  import pkt_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [1:0] PTYPE_DROP = PTYPE_DROP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_dst_addr,
  input  logic [1:0]  in_p_type,
  input  logic [7:0]  in_payload,
  input  logic        in_eop,
  output logic [3:0]  out_valid,
  input  logic [3:0]  out_ready,
  output logic [7:0]  out_payload,
  output logic [1:0]  out_p_type,
  output logic        out_eop,
  output logic [7:0]  drop_count
`ifdef PKT_ROUTER_STATS_EN
  ,
  output logic [31:0] port_pkt_count
`endif
);

  flit_t         fifo_din, fifo_head;
  logic          fifo_full, fifo_empty, fifo_pop;
  router_state_t state_q, state_d;
  logic [1:0]    cur_port_q, cur_port_d;
  logic [1:0]    cur_type_q, cur_type_d;
  logic [7:0]    hold_payload_q, hold_payload_d;
  logic          hold_eop_q, hold_eop_d;
  logic [7:0]    drop_count_q, drop_count_d;
  logic          fwd_valid;

  assign fifo_din = '{dst_addr: in_dst_addr, p_type: in_p_type, payload: in_payload, eop: in_eop};
  assign in_ready = !fifo_full;

  pkt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // IDLE only inspects the head; the first pop happens once FWD/DROP is entered.
  always_comb begin
    state_d        = state_q;
    cur_port_d     = cur_port_q;
    cur_type_d     = cur_type_q;
    hold_payload_d = hold_payload_q;
    hold_eop_d     = hold_eop_q;
    drop_count_d   = drop_count_q;
    fifo_pop       = 1'b0;
    fwd_valid      = 1'b0;
    out_valid      = '0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          cur_port_d = fifo_head.dst_addr;
          cur_type_d = fifo_head.p_type;
          state_d    = (fifo_head.p_type == PTYPE_DROP) ? DROP : FWD;
        end
      end
      FWD: begin
        fwd_valid             = !fifo_empty;
        out_valid[cur_port_q] = fwd_valid;
        fifo_pop              = fwd_valid && out_ready[cur_port_q];
        if (fwd_valid) begin
          hold_payload_d = fifo_head.payload;
          hold_eop_d     = fifo_head.eop;
        end
        if (fifo_pop && fifo_head.eop) state_d = IDLE;
      end
      DROP: begin
        fifo_pop = !fifo_empty;
        if (fifo_pop && fifo_head.eop) begin
          drop_count_d = sat_inc(drop_count_q);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    out_payload = fwd_valid ? fifo_head.payload : hold_payload_q;
    out_eop     = fwd_valid ? fifo_head.eop : hold_eop_q;
  end

  assign out_p_type = cur_type_q;
  assign drop_count = drop_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cur_port_q     <= '0;
      cur_type_q     <= '0;
      hold_payload_q <= '0;
      hold_eop_q     <= 1'b0;
      drop_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      cur_port_q     <= cur_port_d;
      cur_type_q     <= cur_type_d;
      hold_payload_q <= hold_payload_d;
      hold_eop_q     <= hold_eop_d;
      drop_count_q   <= drop_count_d;
    end
  end

`ifdef PKT_ROUTER_STATS_EN
  logic [3:0][7:0] pkt_count_q, pkt_count_d;

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (state_q == FWD && fifo_pop && fifo_head.eop)
      pkt_count_d[cur_port_q] = sat_inc(pkt_count_q[cur_port_q]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pkt_count_q <= '0;
    else     pkt_count_q <= pkt_count_d;
  end

  assign port_pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_pkt_router_4port.sv
// Self-checking bench for pkt_router_4port: constant vector table, directed
// corner sequences and random traffic against a queue-based packet model.
module tb_pkt_router_4port;
  import pkt_pkg::*;

  localparam int DEPTH = 8;

  typedef struct {
    logic       v;
    logic [1:0] dst;
    logic [1:0] pt;
    logic [7:0] pl;
    logic       eop;
    logic [3:0] ordy;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [3:0] e_valid;
    logic [7:0] e_pl;
    logic       e_eop;
    logic       e_rdy;
  } vec_t;

  logic        clk, rst;
  logic        in_valid, in_ready, in_eop, out_eop;
  logic [1:0]  in_dst_addr, in_p_type, out_p_type;
  logic [7:0]  in_payload, out_payload, drop_count;
  logic [3:0]  out_valid, out_ready;
`ifdef PKT_ROUTER_STATS_EN
  logic [31:0] port_pkt_count;
`endif

  pkt_router_4port #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dst_addr (in_dst_addr),
    .in_p_type   (in_p_type),
    .in_payload  (in_payload),
    .in_eop      (in_eop),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .out_p_type  (out_p_type),
    .out_eop     (out_eop),
    .drop_count  (drop_count)
`ifdef PKT_ROUTER_STATS_EN
    ,
    .port_pkt_count (port_pkt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: packets as a flit queue plus "which packet is being served".
  flit_t      m_q[$];
  bit         m_busy, m_drop;
  int         m_port;
  logic [1:0] m_type;
  logic [7:0] m_hold_pl;
  logic       m_hold_eop;
  int         m_drop_cnt;
  int         m_stats[4];

  stim_t      tx_q[$];
  logic [7:0] obs_pl[$];
  logic [3:0] obs_port[$];
  vec_t       vecs[6];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy = 0; m_drop = 0; m_port = 0; m_type = 2'b00;
    m_hold_pl = 8'h00; m_hold_eop = 1'b0; m_drop_cnt = 0;
    for (int i = 0; i < 4; i++) m_stats[i] = 0;
  endtask

  function automatic stim_t mk(input int dst, input int pt, input int pl, input bit eop);
    stim_t s;
    s.v = 1'b1; s.dst = 2'(dst); s.pt = 2'(pt); s.pl = 8'(pl); s.eop = eop; s.ordy = 4'b0000;
    return s;
  endfunction

  function automatic stim_t idle_stim(input logic [3:0] ordy);
    stim_t s;
    s = mk(0, 0, 0, 1'b0);
    s.v = 1'b0; s.ordy = ordy;
    return s;
  endfunction

  // One cycle: drive at negedge, compare against the model, then advance the model.
  task automatic apply_stimulus(input stim_t s, output bit accepted);
    int         sz;
    logic [3:0] e_valid;
    logic [7:0] e_pl;
    logic       e_eop;
    flit_t      f, f_in;
    @(negedge clk);
    in_valid = s.v; in_dst_addr = s.dst; in_p_type = s.pt;
    in_payload = s.pl; in_eop = s.eop; out_ready = s.ordy;
    #1;
    sz      = m_q.size();
    e_valid = (m_busy && !m_drop && sz > 0) ? (4'b0001 << m_port) : 4'b0000;
    e_pl    = (e_valid != 0) ? m_q[0].payload : m_hold_pl;
    e_eop   = (e_valid != 0) ? m_q[0].eop : m_hold_eop;
    check_output("in_ready", in_ready, sz < DEPTH);
    check_output("out_valid", out_valid, e_valid);
    check_output("out_payload", out_payload, e_pl);
    check_output("out_eop", out_eop, e_eop);
    check_output("out_p_type", out_p_type, m_type);
    check_output("drop_count", drop_count, m_drop_cnt);
`ifdef PKT_ROUTER_STATS_EN
    check_output("port_pkt_count", port_pkt_count,
                 {8'(m_stats[3]), 8'(m_stats[2]), 8'(m_stats[1]), 8'(m_stats[0])});
`endif
    if ((out_valid & s.ordy) != 0) begin
      obs_pl.push_back(out_payload);
      obs_port.push_back(out_valid);
    end
    accepted = s.v && (sz < DEPTH);
    if (e_valid != 0) begin
      m_hold_pl = m_q[0].payload; m_hold_eop = m_q[0].eop;
    end
    if (m_busy && sz > 0 && (m_drop || s.ordy[m_port])) begin
      f = m_q.pop_front();
      if (f.eop) begin
        m_busy = 0;
        if (m_drop) m_drop_cnt = (m_drop_cnt < 255) ? m_drop_cnt + 1 : 255;
        else m_stats[m_port] = (m_stats[m_port] < 255) ? m_stats[m_port] + 1 : 255;
      end
    end else if (!m_busy && sz > 0) begin
      m_busy = 1; m_port = int'(m_q[0].dst_addr); m_type = m_q[0].p_type;
      m_drop = (m_q[0].p_type == 2'b11);
    end
    if (accepted) begin
      f_in.dst_addr = s.dst; f_in.p_type = s.pt; f_in.payload = s.pl; f_in.eop = s.eop;
      m_q.push_back(f_in);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 4'b0000;
    #1;
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_out_payload", out_payload, 0);
    check_output("rst_out_eop", out_eop, 0);
    check_output("rst_out_p_type", out_p_type, 0);
    check_output("rst_drop_count", drop_count, 0);
    model_reset();
    obs_pl.delete(); obs_port.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer every queued flit (retrying while stalled), then idle for a while.
  task automatic run_tx(input logic [3:0] ordy, input int idle_cycles);
    int    budget;
    bit    acc;
    stim_t s;
    budget = 200;
    while (tx_q.size() > 0 && budget > 0) begin
      s = tx_q[0]; s.ordy = ordy;
      apply_stimulus(s, acc);
      if (acc) void'(tx_q.pop_front());
      budget--;
    end
    check_output("tx_drained", tx_q.size(), 0);
    tx_q.delete();
    repeat (idle_cycles) apply_stimulus(idle_stim(ordy), acc);
  endtask

  initial begin
    bit    acc;
    int    n_acc, n_done;
    stim_t s;
    rst = 1'b1; in_valid = 0; in_dst_addr = 0; in_p_type = 0;
    in_payload = 0; in_eop = 0; out_ready = 0;
    model_reset();

    // 3-flit packet to port 2: presented two cycles after the first write
    vecs[0] = '{s: mk(2, 0, 8'h11, 0), e_valid: 4'b0000, e_pl: 8'h00, e_eop: 0, e_rdy: 1};
    vecs[1] = '{s: mk(2, 0, 8'h22, 0), e_valid: 4'b0000, e_pl: 8'h00, e_eop: 0, e_rdy: 1};
    vecs[2] = '{s: mk(2, 0, 8'h33, 1), e_valid: 4'b0100, e_pl: 8'h11, e_eop: 0, e_rdy: 1};
    vecs[3] = '{s: idle_stim(4'b1111), e_valid: 4'b0100, e_pl: 8'h22, e_eop: 0, e_rdy: 1};
    vecs[4] = '{s: idle_stim(4'b1111), e_valid: 4'b0100, e_pl: 8'h33, e_eop: 1, e_rdy: 1};
    vecs[5] = '{s: idle_stim(4'b1111), e_valid: 4'b0000, e_pl: 8'h33, e_eop: 1, e_rdy: 1};
    for (int i = 0; i < 3; i++) vecs[i].s.ordy = 4'b1111;

    do_reset();
    $display("[TB] vector table");
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].s, acc);
      check_output($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_valid);
      check_output($sformatf("vec%0d_payload", i), out_payload, vecs[i].e_pl);
      check_output($sformatf("vec%0d_eop", i), out_eop, vecs[i].e_eop);
      check_output($sformatf("vec%0d_ready", i), in_ready, vecs[i].e_rdy);
    end

    $display("[TB] drop packet then normal packet");
    do_reset();
    tx_q = '{mk(1, 3, 8'hE1, 0), mk(1, 3, 8'hE2, 0), mk(1, 3, 8'hE3, 0), mk(1, 3, 8'hE4, 1),
             mk(0, 1, 8'h55, 0), mk(0, 1, 8'h66, 1)};
    run_tx(4'b1111, 10);
    check_output("drop_cnt_after", drop_count, 1);
    check_output("drop_obs_n", obs_pl.size(), 2);
    check_output("drop_obs_pl0", obs_pl[0], 8'h55);
    check_output("drop_obs_pl1", obs_pl[1], 8'h66);
    check_output("drop_obs_port0", obs_port[0], 4'b0001);
    check_output("drop_obs_port1", obs_port[1], 4'b0001);

    $display("[TB] backpressure with full FIFO");
    do_reset();
    for (int i = 0; i < 9; i++) tx_q.push_back(mk(2, 0, 8'hA0 + i, i == 8));
    n_acc = 0;
    for (int c = 0; c < 12; c++) begin
      s = tx_q[0];
      apply_stimulus(s, acc);
      if (acc) begin
        void'(tx_q.pop_front());
        n_acc++;
      end
    end
    check_output("bp_accepted", n_acc, 8);
    check_output("bp_in_ready", in_ready, 0);
    run_tx(4'b0100, 14);
    check_output("bp_obs_n", obs_pl.size(), 9);
    for (int i = 0; i < 9; i++) check_output($sformatf("bp_pl%0d", i), obs_pl[i], 8'hA0 + i);

    $display("[TB] non-first flit dst ignored");
    do_reset();
    tx_q = '{mk(0, 1, 8'h71, 0), mk(3, 0, 8'h72, 0), mk(3, 3, 8'h73, 1)};
    run_tx(4'b1111, 6);
    check_output("dst_obs_n", obs_port.size(), 3);
    for (int i = 0; i < 3; i++) check_output($sformatf("dst_port%0d", i), obs_port[i], 4'b0001);

    $display("[TB] reset mid-packet");
    do_reset();
    apply_stimulus(mk(1, 0, 8'h91, 0), acc);
    apply_stimulus(mk(1, 0, 8'h92, 0), acc);
    @(negedge clk);
    in_payload = 8'h93;
    #2 rst = 1'b1;
    #1;
    check_output("mid_rst_valid", out_valid, 0);
    check_output("mid_rst_payload", out_payload, 0);
    check_output("mid_rst_eop", out_eop, 0);
    check_output("mid_rst_ready", in_ready, 1);
    check_output("mid_rst_ptype", out_p_type, 0);
    in_valid = 1'b0;
    model_reset();
    obs_pl.delete(); obs_port.delete();
    @(negedge clk);
    rst = 1'b0;
    tx_q = '{mk(3, 2, 8'hD1, 0), mk(3, 2, 8'hD2, 1)};
    run_tx(4'b1111, 8);
    check_output("post_rst_n", obs_pl.size(), 2);
    check_output("post_rst_pl0", obs_pl[0], 8'hD1);
    check_output("post_rst_pl1", obs_pl[1], 8'hD2);
    check_output("post_rst_port", obs_port[0] | obs_port[1], 4'b1000);

`ifdef PKT_ROUTER_STATS_EN
    $display("[TB] per-port packet counters");
    do_reset();
    tx_q = '{mk(1, 0, 8'h01, 1), mk(1, 2, 8'h02, 0), mk(1, 2, 8'h03, 1), mk(3, 1, 8'h04, 1)};
    run_tx(4'b1111, 10);
    check_output("stats_counts", port_pkt_count, {8'd1, 8'd0, 8'd2, 8'd0});
`endif

    $display("[TB] random traffic");
    do_reset();
    for (int p = 0; p < 60; p++) begin
      int len, dst, pt;
      len = $urandom_range(4, 1); dst = $urandom_range(3); pt = $urandom_range(3);
      for (int k = 0; k < len; k++)
        tx_q.push_back(mk(dst, (k == 0) ? pt : $urandom_range(3), $urandom_range(255), k == len - 1));
    end
    n_done = 0;
    while (n_done < 1500 && (tx_q.size() > 0 || m_q.size() > 0)) begin
      s = (tx_q.size() > 0) ? tx_q[0] : idle_stim(4'b0000);
      s.v = (tx_q.size() > 0) && ($urandom_range(3) != 0);
      s.ordy = 4'($urandom_range(15));
      apply_stimulus(s, acc);
      if (acc) void'(tx_q.pop_front());
      n_done++;
    end
    check_output("rand_tx_left", tx_q.size(), 0);
    check_output("rand_fifo_left", m_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
